// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state enum, owner encoding, grant one-hot codes and access-size codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Grant one-hot: bit 0 = instruction port, bit 1 = data port
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    function automatic logic size_legal(input logic [1:0] bytes);
        return (bytes == SZ_WORD) || (bytes == SZ_HALF) || (bytes == SZ_BYTE);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between instruction and data requesters.
// On a conflict the port that was not served last wins; a last owner of OWN_I therefore favours data.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  owner_e     last_own,
    output logic [1:0] gnt_oh
);

    always_comb begin
        gnt_oh = GNT_NONE;
        if (i_req && d_req) begin
            gnt_oh = (last_own == OWN_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
            gnt_oh = GNT_D;
        end else if (i_req) begin
            gnt_oh = GNT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single fixed-latency memory, one access in flight.
// Define MEM_ARB_RR_EN for round-robin on conflicts; otherwise the data port always wins.
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_bytes,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_bytes,
    input  logic [31:0] m_rdata
);
    import mem_arb_pkg::*;

    state_e      r_state;
    logic [3:0]  r_cnt;
    owner_e      r_own;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [1:0]  r_bytes;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_i_rvalid;
    logic        r_d_rvalid;

    logic [1:0]  w_gnt;
    logic        w_idle;
    owner_e      w_last_own;

`ifdef MEM_ARB_RR_EN
    owner_e      r_last_own;
    assign w_last_own = r_last_own;
`else
    // Pinning the last owner to OWN_I makes the picker give data fixed priority
    assign w_last_own = OWN_I;
`endif

    mem_arb_pick u_pick (
        .i_req    (i_req),
        .d_req    (d_req),
        .last_own (w_last_own),
        .gnt_oh   (w_gnt)
    );

    assign w_idle = (r_state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_own      <= OWN_I;
            r_addr     <= 32'd0;
            r_we       <= 1'b0;
            r_wdata    <= 32'd0;
            r_bytes    <= SZ_WORD;
            r_i_rdata  <= 32'd0;
            r_d_rdata  <= 32'd0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_own <= OWN_I;
`endif
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt != GNT_NONE) begin
                        r_own   <= w_gnt[1] ? OWN_D : OWN_I;
                        r_addr  <= w_gnt[1] ? d_addr : i_addr;
                        r_we    <= w_gnt[1] & d_we;
                        r_wdata <= w_gnt[1] ? d_wdata : 32'd0;
                        // Fetches are always words; an unencoded data size degrades to word
                        r_bytes <= (w_gnt[1] && size_legal(d_bytes)) ? d_bytes : SZ_WORD;
                        r_cnt   <= 4'(MEM_LAT - 1);
                        r_state <= WAIT;
`ifdef MEM_ARB_RR_EN
                        r_last_own <= w_gnt[1] ? OWN_D : OWN_I;
`endif
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we) begin
                            if (r_own == OWN_I) r_i_rdata <= m_rdata;
                            else                r_d_rdata <= m_rdata;
                        end
                        r_i_rvalid <= (r_own == OWN_I);
                        r_d_rvalid <= (r_own == OWN_D);
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign i_gnt    = w_idle & w_gnt[0];
    assign d_gnt    = w_idle & w_gnt[1];
    assign i_rvalid = r_i_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_rdata  = r_d_rdata;
    assign m_en     = (r_state == WAIT);
    assign m_we     = (r_state == WAIT) & r_we;
    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign m_bytes  = r_bytes;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance on shared stimulus.
// Arbitration expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [1:0]  d_bytes;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [1:0]  m_bytes;

    logic        i_gnt_1, i_rvalid_1, d_gnt_1, d_rvalid_1, m_en_1, m_we_1;
    logic [31:0] i_rdata_1, d_rdata_1, m_addr_1, m_wdata_1;
    logic [1:0]  m_bytes_1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_bytes(d_bytes),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_bytes(m_bytes),
        .m_rdata(m_rdata)
    );

    mem_arbiter #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_1), .i_rvalid(i_rvalid_1), .i_rdata(i_rdata_1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_bytes(d_bytes),
        .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
        .m_en(m_en_1), .m_we(m_we_1), .m_addr(m_addr_1), .m_wdata(m_wdata_1), .m_bytes(m_bytes_1),
        .m_rdata(m_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_i_gnt"},    i_gnt,    0);
        check_eq({tag, "_d_gnt"},    d_gnt,    0);
        check_eq({tag, "_m_en"},     m_en,     0);
        check_eq({tag, "_m_we"},     m_we,     0);
        check_eq({tag, "_i_rvalid"}, i_rvalid, 0);
        check_eq({tag, "_d_rvalid"}, d_rvalid, 0);
        check_eq({tag, "_i_rdata"},  i_rdata,  0);
        check_eq({tag, "_d_rdata"},  d_rdata,  0);
        check_eq({tag, "_m_addr"},   m_addr,   0);
        check_eq({tag, "_m_wdata"},  m_wdata,  0);
        check_eq({tag, "_m_bytes"},  m_bytes,  0);
        check_eq({tag, "_m_en_1"},   m_en_1,   0);
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0]  exp_d;
        logic        own_d;
        logic [31:0] exp_rd;

        reset = 1'b0;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_bytes = 0; m_rdata = 0;

        @(negedge clk);
        check_idle_outputs("rst");
        $display("txn reset: outputs checked while reset low");

        // Fetch, MEM_LAT=2
        next_cycle();
        reset = 1'b1;
        i_req = 1; i_addr = 32'h10; m_rdata = 32'h8C020004;
        @(negedge clk);
        check_eq("if_c0_i_gnt", i_gnt, 1);
        check_eq("if_c0_d_gnt", d_gnt, 0);
        check_eq("if_c0_m_en",  m_en,  0);
        next_cycle(); i_req = 0; i_addr = 32'hFFFF_FFF0;
        @(negedge clk);
        check_eq("if_c1_m_en",    m_en,    1);
        check_eq("if_c1_m_addr",  m_addr,  32'h10);
        check_eq("if_c1_m_we",    m_we,    0);
        check_eq("if_c1_m_bytes", m_bytes, 0);
        check_eq("if_c1_i_gnt",   i_gnt,   0);
        next_cycle();
        @(negedge clk);
        check_eq("if_c2_m_en",     m_en,     1);
        check_eq("if_c2_i_rvalid", i_rvalid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("if_c3_m_en",     m_en,     0);
        check_eq("if_c3_i_rvalid", i_rvalid, 1);
        check_eq("if_c3_i_rdata",  i_rdata,  32'h8C020004);
        check_eq("if_c3_d_rvalid", d_rvalid, 0);
        next_cycle(); m_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        check_eq("if_c4_i_rvalid", i_rvalid, 0);
        check_eq("if_c4_i_rdata",  i_rdata,  32'h8C020004);
        $display("txn fetch: addr 0x10 data 0x8C020004");

        // Data write, MEM_LAT=2
        next_cycle();
        d_req = 1; d_we = 1; d_addr = 32'h54; d_wdata = 32'hDEADBEEF; d_bytes = 2'b01;
        m_rdata = 32'h1234_5678;
        @(negedge clk);
        check_eq("wr_c0_d_gnt", d_gnt, 1);
        check_eq("wr_c0_i_gnt", i_gnt, 0);
        next_cycle(); d_req = 0; d_we = 0; d_wdata = 0; d_bytes = 0; d_addr = 0;
        @(negedge clk);
        check_eq("wr_c1_m_en",    m_en,    1);
        check_eq("wr_c1_m_we",    m_we,    1);
        check_eq("wr_c1_m_bytes", m_bytes, 2'b01);
        check_eq("wr_c1_m_wdata", m_wdata, 32'hDEADBEEF);
        check_eq("wr_c1_m_addr",  m_addr,  32'h54);
        next_cycle();
        @(negedge clk);
        check_eq("wr_c2_m_we",     m_we,     1);
        check_eq("wr_c2_m_wdata",  m_wdata,  32'hDEADBEEF);
        check_eq("wr_c2_d_rvalid", d_rvalid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("wr_c3_d_rvalid", d_rvalid, 1);
        check_eq("wr_c3_d_rdata",  d_rdata,  0);
        check_eq("wr_c3_i_rvalid", i_rvalid, 0);
        check_eq("wr_c3_m_en",     m_en,     0);
        check_eq("wr_c3_i_rdata",  i_rdata,  32'h8C020004);
        next_cycle();
        @(negedge clk);
        check_eq("wr_c4_d_rvalid", d_rvalid, 0);
        $display("txn write: addr 0x54 data 0xDEADBEEF bytes 01");

        // Continuous conflict: four grants from a fresh reset
        do_reset();
`ifdef MEM_ARB_RR_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        exp_rd = 0;
        i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h200; d_addr = 32'h100;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) next_cycle();
            if (c == 13) begin i_req = 0; d_req = 0; end
            m_rdata = 32'hA5A5_0000 + 32'(c);
            @(negedge clk);
            own_d = exp_d[c / 4];
            if (c % 4 == 2) exp_rd = 32'hA5A5_0000 + 32'(c);
            check_eq($sformatf("arb_c%0d_i_gnt", c), i_gnt, (c % 4 == 0) && !own_d);
            check_eq($sformatf("arb_c%0d_d_gnt", c), d_gnt, (c % 4 == 0) && own_d);
            check_eq($sformatf("arb_c%0d_i_rvalid", c), i_rvalid, (c % 4 == 3) && !own_d);
            check_eq($sformatf("arb_c%0d_d_rvalid", c), d_rvalid, (c % 4 == 3) && own_d);
            if (c % 4 == 1) check_eq($sformatf("arb_c%0d_m_addr", c), m_addr, own_d ? 32'h100 : 32'h200);
            if (c % 4 == 3) check_eq($sformatf("arb_c%0d_rdata", c), own_d ? d_rdata : i_rdata, exp_rd);
            if (c % 4 == 0) $display("txn arb grant %0d -> %s", c / 4, own_d ? "D" : "I");
        end

        // Reset in the first WAIT cycle drops the access
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h300; m_rdata = 32'h7777_7777;
        @(negedge clk);
        check_eq("rs_c0_d_gnt", d_gnt, 1);
        next_cycle(); d_req = 0;
        reset = 1'b0;
        #1;
        check_idle_outputs("rs_async");
        next_cycle();
        reset = 1'b1;
        i_req = 1; i_addr = 32'h44; m_rdata = 32'h0000_CAFE;
        @(negedge clk);
        check_eq("rs_rel_i_gnt", i_gnt, 1);
        for (int c = 1; c < 6; c++) begin
            next_cycle();
            i_req = 0;
            @(negedge clk);
            check_eq($sformatf("rs_c%0d_d_rvalid", c), d_rvalid, 0);
            check_eq($sformatf("rs_c%0d_i_rvalid", c), i_rvalid, c == 3);
        end
        check_eq("rs_i_rdata", i_rdata, 32'h0000_CAFE);
        check_eq("rs_d_rdata", d_rdata, 0);
        $display("txn reset-in-flight: dropped, new fetch 0x44 served");

        // MEM_LAT=1 data read on the second instance
        next_cycle();
        d_req = 1; d_we = 0; d_addr = 32'h80; m_rdata = 32'h0000_0001;
        @(negedge clk);
        check_eq("l1_c0_d_gnt", d_gnt_1, 1);
        next_cycle(); d_req = 0;
        @(negedge clk);
        check_eq("l1_c1_m_en",   m_en_1,   1);
        check_eq("l1_c1_m_addr", m_addr_1, 32'h80);
        next_cycle(); m_rdata = 32'h0000_00FF;
        @(negedge clk);
        check_eq("l1_c2_m_en",     m_en_1,     0);
        check_eq("l1_c2_d_rvalid", d_rvalid_1, 1);
        check_eq("l1_c2_d_rdata",  d_rdata_1,  32'h0000_0001);
        next_cycle();
        @(negedge clk);
        check_eq("l1_c3_d_rvalid", d_rvalid_1, 0);
        check_eq("l1_c3_d_rdata",  d_rdata_1,  32'h0000_0001);
        $display("txn lat1 read: addr 0x80 data 0x00000001");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
